uvmt_cv32e40s_sl_obi_req_attr_tracker: RTL and testbench
========================================================

# uvmt_cv32e40s_sl_obi_req_attr_tracker

Support-logic block for the OBI assertion layer. It records a configurable-width attribute of every granted request in a parametrised-depth FIFO and presents the oldest outstanding request's attribute when its response (rvalid) arrives. It also reports outstanding count, a high-water mark and sticky protocol-error flags. It is the generalised successor of the 2-deep attribute FIFO: arbitrary depth and width, explicit full/empty handling and error detection. It is instantiated per OBI bus (instruction, data) alongside the bus interface.

## Interface
- XLEN, 1: attribute width in bits (≥1).
- DEPTH, 2: maximum outstanding transactions tracked (≥1; need not be a power of two).
- CNTW, $clog2(DEPTH+1): width of the count outputs (derived; not overridden).

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- obi_req_i  in  1  OBI req.
- obi_gnt_i  in  1  OBI gnt.
- obi_rvalid_i  in  1  OBI rvalid.
- req_attr_i  in  XLEN  attribute of the current request, sampled on push.
- resp_attr_o  out  XLEN  attribute of the request the current response belongs to; '0 when not valid.
- resp_attr_valid_o  out  1  resp_attr_o is meaningful (rvalid and FIFO not empty).
- outstanding_o  out  CNTW  granted requests not yet responded to.
- max_outstanding_o  out  CNTW  high-water mark of outstanding_o since reset.
- full_o  out  1  outstanding_o == DEPTH.
- empty_o  out  1  outstanding_o == 0.
- overflow_err_o  out  1  sticky; push attempted while full without a simultaneous pop.
- underflow_err_o  out  1  sticky; rvalid while empty.

## Operation
- push = obi_req_i && obi_gnt_i; pop = obi_rvalid_i.
- Push writes req_attr_i at wptr. Pop retires the entry at rptr.
- Pointers wrap from DEPTH-1 to 0.
- resp_attr_o = (pop && !empty) ? mem[rptr] : '0. This is combinational from the current state; a response never returns the attribute of a request pushed in the same cycle.
- The count update depends on push, pop and the empty/full state:
  - Push only, not full: count+1, wptr advances.
  - Pop only, not empty: count-1, rptr advances.
  - Push and pop, not empty: both pointers advance, count unchanged. This includes the full case; no overflow.
  - Push and pop, empty: push accepted, count becomes 1. The pop is an underflow: underflow_err_o is set, resp_attr_valid_o=0.
  - Push only, full: push dropped, state unchanged, overflow_err_o set.
  - Pop only, empty: underflow_err_o set, count stays 0.
- max_outstanding_o updates to the next count whenever the next count exceeds it.
- Error flags are sticky until reset. A flagged condition never corrupts stored entries.

## Timing
- Reset (rst_i high at a clk_i edge) takes effect at that edge:
  - Pointers, count and max_outstanding_o go to 0.
  - Storage is cleared to '0.
  - empty_o=1, full_o=0, both error flags 0.
  - resp_attr_o='0 and resp_attr_valid_o=0 until post-reset state exists.
- Reset mid-operation discards all outstanding entries. An rvalid arriving after reset for a pre-reset request is reported as underflow.
- Push and pop occurring at edge N are visible in outstanding_o, full_o and empty_o after edge N.
- Latency of resp_attr_o: zero cycles from obi_rvalid_i, because the output is combinational from the registered state.
- The block never back-pressures. It is a passive monitor with no ready outputs.

## Structure
- uvmt_cv32e40s_sl_pkg holds an enum for the error cause (none, overflow, underflow), used by assertion messages.
- Sub-module uvmt_cv32e40s_sl_sync_fifo is a generic single-clock FIFO parametrised by WIDTH and DEPTH. It exposes push, pop, rdata, count, full and empty, and wraps pointers modulo DEPTH.
- The top level adds:
  - push/pop derivation;
  - the empty-pop and full-push gating;
  - the high-water mark;
  - the sticky flags.

## Test plan
- Reset: XLEN=4, DEPTH=3, rst_i held 2 cycles -> all outputs at reset values. empty_o=1, outstanding_o=0.
- Ordering: push attrs 0xA, 0x5, 0x3 on consecutive cycles, then 3 rvalids -> resp_attr_o = 0xA, 0x5, 0x3 with valid=1. full_o=1 after the third push. max_outstanding_o=3.
- Simultaneous push and pop:
  - Full, push 0x7 with pop -> resp 0xA, count stays 3, no overflow.
  - Then 3 pops -> 0x5, 0x3, 0x7.
- Overflow: full (DEPTH=3), push 0xF without rvalid -> overflow_err_o=1, count 3. Subsequent pops return only the original 3 values.
- Underflow and wrap: rvalid while empty -> underflow_err_o=1, resp_attr_o=0. Then 7 push/pop pairs exercise wraparound with correct attributes.
- Reset mid-operation: 2 outstanding, assert rst_i, then rvalid -> resp_attr_valid_o=0, underflow_err_o=1, outstanding_o=0.

Source files
------------

// File: rtl/uvmt_cv32e40s_sl_pkg.sv
// Shared types and helpers for the OBI support-logic blocks.
package uvmt_cv32e40s_sl_pkg;

  // Cause of a protocol error flagged by the attribute tracker.
  typedef enum logic [1:0] {
    SL_ERR_NONE      = 2'd0,
    SL_ERR_OVERFLOW  = 2'd1,
    SL_ERR_UNDERFLOW = 2'd2
  } sl_err_e;

  // Advance a pointer by one, wrapping from depth-1 back to 0.
  function automatic int unsigned sl_wrap_inc(input int unsigned ptr,
                                              input int unsigned depth);
    if ((ptr + 32'd1) >= depth) begin
      return 32'd0;
    end else begin
      return ptr + 32'd1;
    end
  endfunction

  // Collapse the two sticky flags into a single cause for reporting.
  function automatic sl_err_e sl_err_cause(input logic ovf, input logic unf);
    if (ovf) begin
      return SL_ERR_OVERFLOW;
    end else if (unf) begin
      return SL_ERR_UNDERFLOW;
    end else begin
      return SL_ERR_NONE;
    end
  endfunction

endpackage

// File: rtl/uvmt_cv32e40s_sl_sync_fifo.sv
// Generic single-clock FIFO with arbitrary (non power-of-two) depth.
// Pointers wrap modulo DEPTH; the occupancy count disambiguates full/empty.
// A push while full is accepted only together with a pop; a pop while empty
// is ignored, so the FIFO is safe even if the caller does not gate.
module uvmt_cv32e40s_sl_sync_fifo
  import uvmt_cv32e40s_sl_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    wptr_d;
  logic [PW-1:0]    rptr_q;
  logic [PW-1:0]    rptr_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == CNT_ZERO);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // Qualify push/pop against occupancy and compute next pointers and count.
  always_comb begin
    pop_ok_s  = pop_i && !empty_o;
    push_ok_s = push_i && (!full_o || pop_ok_s);

    if (push_ok_s) begin
      wptr_d = PW'(sl_wrap_inc(32'(wptr_q), DEPTH));
    end else begin
      wptr_d = wptr_q;
    end

    if (pop_ok_s) begin
      rptr_d = PW'(sl_wrap_inc(32'(rptr_q), DEPTH));
    end else begin
      rptr_d = rptr_q;
    end

    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage: cleared on reset, written only by an accepted push.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_q[wptr_q] <= wdata_i;
    end else begin
      mem_q[wptr_q] <= mem_q[wptr_q];
    end
  end

endmodule

// File: rtl/uvmt_cv32e40s_sl_obi_req_attr_tracker.sv
// OBI request attribute tracker: remembers an attribute of every granted
// request and presents the oldest outstanding one alongside its rvalid.
// Also reports occupancy, a high-water mark and sticky protocol errors.
module uvmt_cv32e40s_sl_obi_req_attr_tracker
  import uvmt_cv32e40s_sl_pkg::*;
#(
  parameter int XLEN  = 1,
  parameter int DEPTH = 2,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            obi_req_i,
  input  logic            obi_gnt_i,
  input  logic            obi_rvalid_i,
  input  logic [XLEN-1:0] req_attr_i,
  output logic [XLEN-1:0] resp_attr_o,
  output logic            resp_attr_valid_o,
  output logic [CNTW-1:0] outstanding_o,
  output logic [CNTW-1:0] max_outstanding_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            overflow_err_o,
  output logic            underflow_err_o
);

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  logic            push_s;
  logic            pop_s;
  logic            push_ok_s;
  logic            pop_ok_s;
  logic [XLEN-1:0] rdata_s;
  logic [CNTW-1:0] count_s;
  logic            full_s;
  logic            empty_s;
  logic [CNTW-1:0] count_nxt_s;
  logic [CNTW-1:0] max_q;
  logic [CNTW-1:0] max_d;
  logic            ovf_q;
  logic            ovf_d;
  logic            unf_q;
  logic            unf_d;

  // Raw handshake decode and gating: an empty-pop is never retired, and a
  // full-push is only accepted when an entry retires in the same cycle.
  always_comb begin
    push_s    = obi_req_i && obi_gnt_i;
    pop_s     = obi_rvalid_i;
    pop_ok_s  = pop_s && !empty_s;
    push_ok_s = push_s && (!full_s || pop_ok_s);
  end

  uvmt_cv32e40s_sl_sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH),
    .CW    (CNTW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_ok_s),
    .pop_i   (pop_ok_s),
    .wdata_i (req_attr_i),
    .rdata_o (rdata_s),
    .count_o (count_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Response attribute is combinational from stored state, so a response
  // can never see the attribute of a request pushed in the same cycle.
  always_comb begin
    if (pop_ok_s) begin
      resp_attr_o       = rdata_s;
      resp_attr_valid_o = 1'b1;
    end else begin
      resp_attr_o       = '0;
      resp_attr_valid_o = 1'b0;
    end
  end

  // Next occupancy, high-water mark and sticky error flags.
  always_comb begin
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_s + CNT_ONE;
      2'b01:   count_nxt_s = count_s - CNT_ONE;
      default: count_nxt_s = count_s;
    endcase

    if (count_nxt_s > max_q) begin
      max_d = count_nxt_s;
    end else begin
      max_d = max_q;
    end

    ovf_d = ovf_q || (push_s && full_s && !pop_s);
    unf_d = unf_q || (pop_s && empty_s);
  end

  // Status registers, all cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      max_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      max_q <= max_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign outstanding_o     = count_s;
  assign max_outstanding_o = max_q;
  assign full_o            = full_s;
  assign empty_o           = empty_s;
  assign overflow_err_o    = ovf_q;
  assign underflow_err_o   = unf_q;

endmodule

// File: tb/tb_uvmt_cv32e40s_sl_obi_req_attr_tracker.sv
// Directed, scoreboard-based bench for the OBI request attribute tracker.
module tb_uvmt_cv32e40s_sl_obi_req_attr_tracker;
  import uvmt_cv32e40s_sl_pkg::*;

  localparam int XLEN  = 4;
  localparam int DEPTH = 3;
  localparam int CNTW  = $clog2(DEPTH + 1);

  logic            clk;
  logic            rst;
  logic            req;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] attr;
  logic [XLEN-1:0] resp_attr;
  logic            resp_valid;
  logic [CNTW-1:0] outstanding;
  logic [CNTW-1:0] max_out;
  logic            full;
  logic            empty;
  logic            ovf;
  logic            unf;

  int checks = 0;
  int errors = 0;

  // Scoreboard of attributes expected to come back, plus model status.
  logic [XLEN-1:0] sb_q[$];
  int              m_max = 0;
  logic            m_ovf = 1'b0;
  logic            m_unf = 1'b0;
  logic [XLEN-1:0] last_resp;

  uvmt_cv32e40s_sl_obi_req_attr_tracker #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .obi_req_i         (req),
    .obi_gnt_i         (gnt),
    .obi_rvalid_i      (rvalid),
    .req_attr_i        (attr),
    .resp_attr_o       (resp_attr),
    .resp_attr_valid_o (resp_valid),
    .outstanding_o     (outstanding),
    .max_outstanding_o (max_out),
    .full_o            (full),
    .empty_o           (empty),
    .overflow_err_o    (ovf),
    .underflow_err_o   (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Registered status versus the model, sampled after the edge.
  task automatic chk_status(input string tag);
    chk({tag, ".outstanding"}, 32'(outstanding), 32'(sb_q.size()));
    chk({tag, ".max"},         32'(max_out),     32'(m_max));
    chk({tag, ".full"},        32'(full),        32'(sb_q.size() == DEPTH));
    chk({tag, ".empty"},       32'(empty),       32'(sb_q.size() == 0));
    chk({tag, ".ovf"},         32'(ovf),         32'(m_ovf));
    chk({tag, ".unf"},         32'(unf),         32'(m_unf));
  endtask

  // One bus cycle: drive, check the combinational response, update model, clock.
  task automatic step(input string tag, input logic p, input logic v, input logic [XLEN-1:0] a);
    logic pop_ok;
    logic push_ok;
    logic [XLEN-1:0] exp_attr;
    @(negedge clk);
    req = p; gnt = p; rvalid = v; attr = a;
    #1;
    pop_ok   = v && (sb_q.size() > 0);
    exp_attr = pop_ok ? sb_q[0] : '0;
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'(pop_ok));
    chk({tag, ".resp_attr"},  32'(resp_attr),  32'(exp_attr));
    last_resp = resp_attr;
    push_ok = p && ((sb_q.size() < DEPTH) || pop_ok);
    if (p && (sb_q.size() == DEPTH) && !v) m_ovf = 1'b1;
    if (v && (sb_q.size() == 0)) m_unf = 1'b1;
    if (pop_ok) void'(sb_q.pop_front());
    if (push_ok) sb_q.push_back(a);
    if (sb_q.size() > m_max) m_max = sb_q.size();
    @(posedge clk);
    #1;
    chk_status(tag);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1; req = 1'b0; gnt = 1'b0; rvalid = 1'b0; attr = '0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    m_max = 0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; gnt = 1'b0; rvalid = 1'b0; attr = '0;

    // Reset values.
    do_reset(2);
    chk_status("reset");
    chk("reset.resp_attr",  32'(resp_attr),  32'h0);
    chk("reset.resp_valid", 32'(resp_valid), 32'h0);

    // Ordering.
    step("ord.push0", 1'b1, 1'b0, 4'hA);
    step("ord.push1", 1'b1, 1'b0, 4'h5);
    step("ord.push2", 1'b1, 1'b0, 4'h3);
    chk("ord.full_const", 32'(full), 32'h1);
    step("ord.pop0", 1'b0, 1'b1, 4'h0);
    chk("ord.r0", 32'(last_resp), 32'hA);
    step("ord.pop1", 1'b0, 1'b1, 4'h0);
    chk("ord.r1", 32'(last_resp), 32'h5);
    step("ord.pop2", 1'b0, 1'b1, 4'h0);
    chk("ord.r2", 32'(last_resp), 32'h3);
    chk("ord.max_const", 32'(max_out), 32'h3);

    // Simultaneous push and pop while full.
    step("sim.push0", 1'b1, 1'b0, 4'hA);
    step("sim.push1", 1'b1, 1'b0, 4'h5);
    step("sim.push2", 1'b1, 1'b0, 4'h3);
    step("sim.pp",    1'b1, 1'b1, 4'h7);
    chk("sim.pp_resp",  32'(last_resp),   32'hA);
    chk("sim.pp_count", 32'(outstanding), 32'h3);
    chk("sim.pp_ovf",   32'(ovf),         32'h0);
    step("sim.pop0", 1'b0, 1'b1, 4'h0);
    chk("sim.r0", 32'(last_resp), 32'h5);
    step("sim.pop1", 1'b0, 1'b1, 4'h0);
    chk("sim.r1", 32'(last_resp), 32'h3);
    step("sim.pop2", 1'b0, 1'b1, 4'h0);
    chk("sim.r2", 32'(last_resp), 32'h7);

    // Overflow.
    step("ovf.push0", 1'b1, 1'b0, 4'hA);
    step("ovf.push1", 1'b1, 1'b0, 4'h5);
    step("ovf.push2", 1'b1, 1'b0, 4'h3);
    step("ovf.pushF", 1'b1, 1'b0, 4'hF);
    chk("ovf.flag_const",  32'(ovf),         32'h1);
    chk("ovf.count_const", 32'(outstanding), 32'h3);
    step("ovf.pop0", 1'b0, 1'b1, 4'h0);
    chk("ovf.r0", 32'(last_resp), 32'hA);
    step("ovf.pop1", 1'b0, 1'b1, 4'h0);
    chk("ovf.r1", 32'(last_resp), 32'h5);
    step("ovf.pop2", 1'b0, 1'b1, 4'h0);
    chk("ovf.r2", 32'(last_resp), 32'h3);
    chk("ovf.cause", 32'(sl_err_cause(ovf, unf)), 32'(SL_ERR_OVERFLOW));

    // Underflow, then wraparound with push/pop pairs.
    step("unf.pop", 1'b0, 1'b1, 4'h0);
    chk("unf.flag_const", 32'(unf),       32'h1);
    chk("unf.resp_const", 32'(last_resp), 32'h0);
    step("wrap.seed", 1'b1, 1'b0, 4'h1);
    for (int i = 0; i < 7; i++) begin
      step($sformatf("wrap.pp%0d", i), 1'b1, 1'b1, 4'(i + 2));
      chk($sformatf("wrap.r%0d", i), 32'(last_resp), 32'(i + 1));
    end
    step("wrap.drain", 1'b0, 1'b1, 4'h0);
    chk("wrap.last", 32'(last_resp), 32'h8);

    // Reset mid-operation discards outstanding entries.
    step("mid.push0", 1'b1, 1'b0, 4'h9);
    step("mid.push1", 1'b1, 1'b0, 4'hC);
    do_reset(1);
    chk_status("mid.after_reset");
    step("mid.rvalid", 1'b0, 1'b1, 4'h0);
    chk("mid.valid_const", 32'(resp_valid),  32'h0);
    chk("mid.unf_const",   32'(unf),         32'h1);
    chk("mid.count_const", 32'(outstanding), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
